load_store_unit: RTL

- Initiator side of the data-memory interface: accepts byte/half/word load and store requests from the execute stage and drives the word-organised data_memory port (address, mem_read, mem_write, write_data, read_data).
- Performs address-to-word translation, load extraction with sign/zero extension, and read-modify-write for sub-word stores.
- Returns one response per request over a valid/ready handshake.

---
 rtl/load_store_unit_if.sv | 39 +++
 rtl/load_store_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Bundles the request, response and data-memory signals of the load/store unit.
// The slave modport is the unit itself; the master modport is the surrounding
// environment (execute stage, response consumer and data memory).
interface load_store_unit_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_read, mem_write, mem_write_data
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_read, mem_write, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts byte/half/word requests, translates byte addresses to
// word indices, extracts and extends load lanes, and performs read-modify-write
// for sub-word stores. One request is in flight at a time.
module load_store_unit #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
) (
    input logic              clk,
    input logic              reset_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic              we_q;
    logic              unsigned_q;
    logic [1:0]        size_q;
    logic [1:0]        lane_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept;
    logic              req_err;
    logic [DATA_W-1:0] load_value;
    logic [DATA_W-1:0] merged_word;

    assign accept  = (state_q == IDLE) && bus.req_valid;
    assign req_err = (bus.req_size == 2'b11)
                   || ((bus.req_size == 2'b01) && bus.req_addr[0])
                   || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));

    // Strobes and handshake flags decode straight from the state, so reset clears them at once.
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.mem_read   = (state_q == RD) || (state_q == CAP);
    assign bus.mem_write  = (state_q == WR);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection: errors skip memory, word stores skip the read, sub-word stores read first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_d = RESP;
                    end else if (bus.req_we && (bus.req_size == 2'b10)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = CAP;
            CAP:     state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = bus.resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // Lane extraction/extension for loads and lane merge for sub-word stores, little-endian.
    always_comb begin
        load_value  = '0;
        merged_word = bus.mem_read_data;
        case (size_q)
            2'b00: begin
                load_value[7:0] = bus.mem_read_data[{lane_q, 3'b000} +: 8];
                if (!unsigned_q) begin
                    load_value[DATA_W-1:8] = {(DATA_W-8){load_value[7]}};
                end
                merged_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_value[15:0] = bus.mem_read_data[{lane_q[1], 4'b0000} +: 16];
                if (!unsigned_q) begin
                    load_value[DATA_W-1:16] = {(DATA_W-16){load_value[15]}};
                end
                merged_word[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: begin
                load_value = bus.mem_read_data;
            end
        endcase
    end

    // Request latching, memory address/data registers and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q               <= 1'b0;
            unsigned_q         <= 1'b0;
            size_q             <= 2'b00;
            lane_q             <= 2'b00;
            wdata_q            <= '0;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
            bus.resp_rdata     <= '0;
            bus.resp_err       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q       <= bus.req_we;
                        unsigned_q <= bus.req_unsigned;
                        size_q     <= bus.req_size;
                        lane_q     <= bus.req_addr[1:0];
                        wdata_q    <= bus.req_wdata;
                        if (req_err) begin
                            bus.resp_err <= 1'b1;
                        end else begin
                            bus.mem_address <= {2'b00, bus.req_addr[ADDR_W-1:2]};
                            if (bus.req_we && (bus.req_size == 2'b10)) begin
                                bus.mem_write_data <= bus.req_wdata;
                            end
                        end
                    end
                end
                CAP: begin
                    if (we_q) begin
                        bus.mem_write_data <= merged_word;
                    end else begin
                        bus.resp_rdata <= load_value;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_rdata <= '0;
                        bus.resp_err   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
